yukseklik_komut_verici: RTL and testbench

Initiator side of the target-altitude command interface of the flight controller FSM. It accepts an operator altitude request and range-checks it locally. It then drives the target-altitude bus with a one-cycle "altitude info" strobe and waits for the flight FSM's green/red LED feedback, retrying on timeout. It sits on the ground-station/command side and reports success or failure with an error code.

---
 rtl/yukseklik_komut_pkg.sv | 25 ++
 rtl/zaman_asimi_sayaci.sv | 30 +++
 rtl/yukseklik_komut_verici.sv | 138 +++++++++++++
 tb/tb_yukseklik_komut_verici.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yukseklik_komut_pkg.sv
// Shared definitions for the target-altitude command interface: FSM states,
// error codes and the default altitude window also used by the flight FSM.
package yukseklik_komut_pkg;

    typedef enum logic [1:0] {
        S_BOS    = 2'b00,
        S_GONDER = 2'b01,
        S_BEKLE  = 2'b10,
        S_SONUC  = 2'b11
    } durum_t;

    localparam logic [1:0] HATA_YOK     = 2'b00;
    localparam logic [1:0] HATA_ARALIK  = 2'b01;
    localparam logic [1:0] HATA_KIRMIZI = 2'b10;
    localparam logic [1:0] HATA_ZAMAN   = 2'b11;

    localparam int VARSAYILAN_MIN_YUKSEKLIK = 10;
    localparam int VARSAYILAN_MAX_YUKSEKLIK = 100;

    // Inclusive window check on an unsigned 8-bit altitude.
    function automatic logic aralikta(input logic [7:0] deger, input int alt, input int ust);
        return (int'(deger) >= alt) && (int'(deger) <= ust);
    endfunction

endpackage

// File: rtl/zaman_asimi_sayaci.sv
// Feedback timeout counter: clear has priority, counts while enabled and
// raises bitti_o while enabled at the terminal value ZAMAN_ASIMI-1.
module zaman_asimi_sayaci #(
    parameter int ZAMAN_ASIMI = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic temizle_i,
    input  logic sayac_en_i,
    output logic bitti_o
);

    localparam int W = $clog2(ZAMAN_ASIMI);
    localparam logic [W-1:0] SON = W'(ZAMAN_ASIMI - 1);

    logic [W-1:0] sayac_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sayac_q <= '0;
        end else if (temizle_i) begin
            sayac_q <= '0;
        end else if (sayac_en_i && (sayac_q != SON)) begin
            sayac_q <= sayac_q + W'(1);
        end
    end

    assign bitti_o = sayac_en_i && (sayac_q == SON);

endmodule

// File: rtl/yukseklik_komut_verici.sv
// Initiator of the target-altitude command: range-checks an operator request,
// strobes it to the flight FSM and waits for LED feedback with bounded retries.
module yukseklik_komut_verici
    import yukseklik_komut_pkg::*;
#(
    parameter int MIN_YUKSEKLIK = VARSAYILAN_MIN_YUKSEKLIK,
    parameter int MAX_YUKSEKLIK = VARSAYILAN_MAX_YUKSEKLIK,
    parameter int ZAMAN_ASIMI   = 1000,
    parameter int MAX_DENEME    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       komut_gecerli_i,
    input  logic [7:0] komut_yukseklik_i,
    input  logic       yesil_led_i,
    input  logic       kirmizi_led_i,
    output logic [7:0] hedef_yukseklik_o,
    output logic       yukseklik_bilgisi_o,
    output logic       mesgul_o,
    output logic       basarili_o,
    output logic       basarisiz_o,
    output logic [1:0] hata_kodu_o,
    output logic [1:0] deneme_o
);

    localparam logic [1:0] DENEME_SON = 2'(MAX_DENEME);

    durum_t     durum_q;
    logic [7:0] hedef_q;
    logic       bilgi_q;
    logic       mesgul_q;
    logic       basarili_q;
    logic       basarisiz_q;
    logic       basari_q;
    logic [1:0] hata_q;
    logic [1:0] deneme_q;

    logic aralik_ok;
    logic kabul;
    logic yeniden_dene;
    logic zaman_doldu;
    logic sayac_en;

    assign aralik_ok    = aralikta(komut_yukseklik_i, MIN_YUKSEKLIK, MAX_YUKSEKLIK);
    assign kabul        = (durum_q == S_BOS) && komut_gecerli_i && aralik_ok;
    assign yeniden_dene = (durum_q == S_BEKLE) && !kirmizi_led_i && !yesil_led_i
                          && zaman_doldu && (deneme_q < DENEME_SON);
    assign sayac_en     = (durum_q == S_GONDER) || (durum_q == S_BEKLE);

    // Timer is cleared on entry to S_GONDER and also runs during the strobe
    // cycle, so consecutive strobes are exactly ZAMAN_ASIMI cycles apart.
    zaman_asimi_sayaci #(
        .ZAMAN_ASIMI(ZAMAN_ASIMI)
    ) u_sayac (
        .clk       (clk),
        .rst_n     (rst_n),
        .temizle_i (kabul || yeniden_dene),
        .sayac_en_i(sayac_en),
        .bitti_o   (zaman_doldu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q     <= S_BOS;
            hedef_q     <= '0;
            bilgi_q     <= 1'b0;
            mesgul_q    <= 1'b0;
            basarili_q  <= 1'b0;
            basarisiz_q <= 1'b0;
            basari_q    <= 1'b0;
            hata_q      <= HATA_YOK;
            deneme_q    <= '0;
        end else begin
            bilgi_q     <= 1'b0;
            basarili_q  <= 1'b0;
            basarisiz_q <= 1'b0;
            case (durum_q)
                S_BOS: begin
                    if (komut_gecerli_i) begin
                        hedef_q  <= komut_yukseklik_i;
                        deneme_q <= '0;
                        mesgul_q <= 1'b1;
                        if (aralik_ok) begin
                            hata_q  <= HATA_YOK;
                            bilgi_q <= 1'b1;
                            durum_q <= S_GONDER;
                        end else begin
                            hata_q   <= HATA_ARALIK;
                            basari_q <= 1'b0;
                            durum_q  <= S_SONUC;
                        end
                    end
                end
                S_GONDER: begin
                    if (deneme_q < DENEME_SON) begin
                        deneme_q <= deneme_q + 2'd1;
                    end
                    durum_q <= S_BEKLE;
                end
                S_BEKLE: begin
                    // Red beats green, and any feedback beats the timeout.
                    if (kirmizi_led_i) begin
                        hata_q   <= HATA_KIRMIZI;
                        basari_q <= 1'b0;
                        durum_q  <= S_SONUC;
                    end else if (yesil_led_i) begin
                        basari_q <= 1'b1;
                        durum_q  <= S_SONUC;
                    end else if (zaman_doldu) begin
                        if (deneme_q < DENEME_SON) begin
                            bilgi_q <= 1'b1;
                            durum_q <= S_GONDER;
                        end else begin
                            hata_q   <= HATA_ZAMAN;
                            basari_q <= 1'b0;
                            durum_q  <= S_SONUC;
                        end
                    end
                end
                S_SONUC: begin
                    basarili_q  <= basari_q;
                    basarisiz_q <= !basari_q;
                    mesgul_q    <= 1'b0;
                    durum_q     <= S_BOS;
                end
            endcase
        end
    end

    assign hedef_yukseklik_o   = hedef_q;
    assign yukseklik_bilgisi_o = bilgi_q;
    assign mesgul_o            = mesgul_q;
    assign basarili_o          = basarili_q;
    assign basarisiz_o         = basarisiz_q;
    assign hata_kodu_o         = hata_q;
    assign deneme_o            = deneme_q;

endmodule

// File: tb/tb_yukseklik_komut_verici.sv
// Bench for yukseklik_komut_verici: directed commands, scoreboard queues for
// strobes and result pulses, checked by a negedge monitor.
module tb_yukseklik_komut_verici;

    localparam int ZA = 8;
    localparam int MD = 3;

    logic       clk;
    logic       rst_n;
    logic       komut_gecerli;
    logic [7:0] komut_yukseklik;
    logic       yesil;
    logic       kirmizi;
    logic [7:0] hedef_yukseklik;
    logic       yukseklik_bilgisi;
    logic       mesgul;
    logic       basarili;
    logic       basarisiz;
    logic [1:0] hata_kodu;
    logic [1:0] deneme;

    logic [31:0] cyc;
    int          checks;
    int          errors;

    // {cycle, hedef} per expected strobe; {cycle, basarili, basarisiz, hata, deneme} per result.
    logic [39:0] exp_strobe_q[$];
    logic [37:0] exp_sonuc_q[$];
    logic [39:0] mon_strobe;
    logic [37:0] mon_sonuc;

    yukseklik_komut_verici #(
        .MIN_YUKSEKLIK(10),
        .MAX_YUKSEKLIK(100),
        .ZAMAN_ASIMI  (ZA),
        .MAX_DENEME   (MD)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .komut_gecerli_i    (komut_gecerli),
        .komut_yukseklik_i  (komut_yukseklik),
        .yesil_led_i        (yesil),
        .kirmizi_led_i      (kirmizi),
        .hedef_yukseklik_o  (hedef_yukseklik),
        .yukseklik_bilgisi_o(yukseklik_bilgisi),
        .mesgul_o           (mesgul),
        .basarili_o         (basarili),
        .basarisiz_o        (basarisiz),
        .hata_kodu_o        (hata_kodu),
        .deneme_o           (deneme)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic bekle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic komut_ver(input logic [7:0] v, output int c);
        komut_gecerli   = 1'b1;
        komut_yukseklik = v;
        @(posedge clk);
        #1;
        komut_gecerli   = 1'b0;
        komut_yukseklik = 8'h00;
        c = int'(cyc);
    endtask

    task automatic led_darbe(input int gecikme, input logic k, input logic y);
        repeat (gecikme) @(posedge clk);
        #1;
        kirmizi = k;
        yesil   = y;
        @(posedge clk);
        #1;
        kirmizi = 1'b0;
        yesil   = 1'b0;
    endtask

    task automatic beklenen_strobe(input int c, input logic [7:0] v);
        exp_strobe_q.push_back({32'(c), v});
    endtask

    task automatic beklenen_sonuc(input int c, input logic b, input logic bz,
                                  input logic [1:0] h, input logic [1:0] d);
        exp_sonuc_q.push_back({32'(c), b, bz, h, d});
    endtask

    task automatic kontrol(input string ad, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", ad, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or result
    always @(negedge clk) begin
        if (rst_n) begin
            if (yukseklik_bilgisi) begin
                checks++;
                if (exp_strobe_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: got strobe at cycle %0d hedef %0d, required none",
                             cyc, hedef_yukseklik);
                end else begin
                    mon_strobe = exp_strobe_q.pop_front();
                    if ({cyc, hedef_yukseklik} !== mon_strobe) begin
                        errors++;
                        $display("FAIL strobe: got cycle %0d hedef %0d, required cycle %0d hedef %0d",
                                 cyc, hedef_yukseklik, mon_strobe[39:8], mon_strobe[7:0]);
                    end
                end
            end
            if (basarili || basarisiz) begin
                checks++;
                if (exp_sonuc_q.size() == 0) begin
                    errors++;
                    $display("FAIL sonuc_unexpected: got pulse at cycle %0d ok %0b nok %0b hata %0d deneme %0d, required none",
                             cyc, basarili, basarisiz, hata_kodu, deneme);
                end else begin
                    mon_sonuc = exp_sonuc_q.pop_front();
                    if ({cyc, basarili, basarisiz, hata_kodu, deneme} !== mon_sonuc) begin
                        errors++;
                        $display("FAIL sonuc: got cycle %0d ok %0b nok %0b hata %0d deneme %0d, required cycle %0d ok %0b nok %0b hata %0d deneme %0d",
                                 cyc, basarili, basarisiz, hata_kodu, deneme,
                                 mon_sonuc[37:6], mon_sonuc[5], mon_sonuc[4], mon_sonuc[3:2], mon_sonuc[1:0]);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int c;
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        komut_gecerli   = 1'b0;
        komut_yukseklik = 8'h00;
        yesil           = 1'b0;
        kirmizi         = 1'b0;

        bekle(3);
        kontrol("reset_outputs", {hedef_yukseklik, yukseklik_bilgisi, mesgul, basarili,
                                  basarisiz, hata_kodu, deneme}, 16'h0000);
        rst_n = 1'b1;
        bekle(2);
        kontrol("idle_outputs", {hedef_yukseklik, yukseklik_bilgisi, mesgul, basarili,
                                 basarisiz, hata_kodu, deneme}, 16'h0000);

        // Valid 50, green 5 cycles after the strobe
        komut_ver(8'd50, c);
        beklenen_strobe(c, 8'd50);
        beklenen_sonuc(c + 7, 1'b1, 1'b0, 2'b00, 2'd1);
        led_darbe(5, 1'b0, 1'b1);
        bekle(4);
        kontrol("hold_after_ok", {hedef_yukseklik, 4'h0, hata_kodu, deneme}, {8'd50, 4'h0, 2'b00, 2'd1});

        // Out-of-range requests
        komut_ver(8'd9, c);
        beklenen_sonuc(c + 1, 1'b0, 1'b1, 2'b01, 2'd0);
        bekle(3);
        kontrol("hold_range_9", {8'h00, 6'h0, hata_kodu}, {8'h00, 6'h0, 2'b01});
        komut_ver(8'd101, c);
        beklenen_sonuc(c + 1, 1'b0, 1'b1, 2'b01, 2'd0);
        bekle(3);
        kontrol("hedef_101", {8'h00, hedef_yukseklik}, {8'h00, 8'd101});

        // Boundary values, no feedback: three strobes 8 apart, then timeout
        komut_ver(8'd10, c);
        beklenen_strobe(c, 8'd10);
        beklenen_strobe(c + 8, 8'd10);
        beklenen_strobe(c + 16, 8'd10);
        beklenen_sonuc(c + 25, 1'b0, 1'b1, 2'b11, 2'd3);
        bekle(28);
        komut_ver(8'd100, c);
        beklenen_strobe(c, 8'd100);
        beklenen_strobe(c + 8, 8'd100);
        beklenen_strobe(c + 16, 8'd100);
        beklenen_sonuc(c + 25, 1'b0, 1'b1, 2'b11, 2'd3);
        bekle(28);

        // Red during first wait, then red and green together
        komut_ver(8'd80, c);
        beklenen_strobe(c, 8'd80);
        beklenen_sonuc(c + 5, 1'b0, 1'b1, 2'b10, 2'd1);
        led_darbe(3, 1'b1, 1'b0);
        bekle(4);
        komut_ver(8'd81, c);
        beklenen_strobe(c, 8'd81);
        beklenen_sonuc(c + 4, 1'b0, 1'b1, 2'b10, 2'd1);
        led_darbe(2, 1'b1, 1'b1);
        bekle(4);

        // Extra requests during S_BEKLE are ignored
        komut_ver(8'd60, c);
        beklenen_strobe(c, 8'd60);
        beklenen_sonuc(c + 6, 1'b1, 1'b0, 2'b00, 2'd1);
        bekle(2);
        komut_gecerli   = 1'b1;
        komut_yukseklik = 8'd200;
        bekle(1);
        komut_yukseklik = 8'd30;
        bekle(1);
        komut_gecerli   = 1'b0;
        komut_yukseklik = 8'h00;
        yesil           = 1'b1;
        bekle(1);
        yesil           = 1'b0;
        bekle(3);
        kontrol("hedef_after_ignored", {8'h00, hedef_yukseklik}, {8'h00, 8'd60});

        // Asynchronous reset mid-wait, then a fresh request
        komut_ver(8'd70, c);
        beklenen_strobe(c, 8'd70);
        bekle(3);
        kontrol("busy_before_reset", {15'h0, mesgul}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        kontrol("async_reset_outputs", {hedef_yukseklik, yukseklik_bilgisi, mesgul, basarili,
                                        basarisiz, hata_kodu, deneme}, 16'h0000);
        bekle(2);
        rst_n = 1'b1;
        bekle(2);
        komut_ver(8'd20, c);
        beklenen_strobe(c, 8'd20);
        beklenen_sonuc(c + 4, 1'b1, 1'b0, 2'b00, 2'd1);
        led_darbe(2, 1'b0, 1'b1);
        bekle(4);

        // Green exactly on the timeout cycle of attempt 2
        komut_ver(8'd40, c);
        beklenen_strobe(c, 8'd40);
        beklenen_strobe(c + 8, 8'd40);
        beklenen_sonuc(c + 17, 1'b1, 1'b0, 2'b00, 2'd2);
        led_darbe(15, 1'b0, 1'b1);
        bekle(12);
        kontrol("deneme_held_2", {14'h0, deneme}, 16'd2);

        // Final report
        kontrol("strobe_queue_drained", 16'(exp_strobe_q.size()), 16'd0);
        kontrol("sonuc_queue_drained", 16'(exp_sonuc_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
